// File: rtl/prim_subreg_pkg.sv
// rtl/prim_subreg_pkg.sv - shared types and constants for the subreg command queue
package prim_subreg_pkg;

  localparam int CmdqDropCntW = 8;

  typedef struct packed {
    logic ovf;
    logic full;
  } cmdq_sts_t;

endpackage

// File: rtl/prim_subreg_cmdq_fifo.sv
// rtl/prim_subreg_cmdq_fifo.sv - in-order storage with push/pop qualification and occupancy
module prim_subreg_cmdq_fifo #(
  parameter int DW    = 32,
  parameter int Depth = 4,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wvalid_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            rready_i,
  output logic            rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic [CntW-1:0] lvl_o,
  output logic            full_o,
  output logic            drop_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DW-1:0]   mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] lvl_q, lvl_d;
  logic            full, push, pop;

  // Explicit wrap so non-power-of-2 depths stay in range.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (lvl_q == CntW'(Depth));
  assign rvalid_o = (lvl_q != '0);
  assign pop      = rvalid_o & rready_i;
  assign push     = wvalid_i & (~full | pop);
  assign drop_o   = wvalid_i & full & ~pop;
  assign rdata_o  = mem_q[rd_ptr_q];
  assign lvl_o    = lvl_q;
  assign full_o   = full;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    lvl_d    = lvl_q;
    if (push && !pop) begin
      lvl_d = lvl_q + 1'b1;
    end else if (pop && !push) begin
      lvl_d = lvl_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/prim_subreg_cmdq.sv
// rtl/prim_subreg_cmdq.sv - queues register write strobes for HW and reports overflow status
module prim_subreg_cmdq
  import prim_subreg_pkg::*;
#(
  parameter  int DW    = 32,
  parameter  int Depth = 4,
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    qe_i,
  input  logic [DW-1:0]           q_i,
  output logic                    cmd_valid_o,
  output logic [DW-1:0]           cmd_data_o,
  input  logic                    cmd_ready_i,
  output logic [CntW-1:0]         lvl_o,
  input  logic                    ovf_clr_i,
  output logic                    sts_de_o,
  output logic [1:0]              sts_d_o,
  output logic [CmdqDropCntW-1:0] drop_cnt_o
);

  logic                    full, drop;
  logic                    ovf_q, ovf_d;
  logic [CmdqDropCntW-1:0] drop_cnt_q, drop_cnt_d;
  cmdq_sts_t               sts_cur, sts_prev_q;

  prim_subreg_cmdq_fifo #(
    .DW    (DW),
    .Depth (Depth),
    .CntW  (CntW)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wvalid_i (qe_i),
    .wdata_i  (q_i),
    .rready_i (cmd_ready_i),
    .rvalid_o (cmd_valid_o),
    .rdata_o  (cmd_data_o),
    .lvl_o    (lvl_o),
    .full_o   (full),
    .drop_o   (drop)
  );

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr_i) begin
        drop_cnt_d = CmdqDropCntW'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end else if (ovf_clr_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      sts_prev_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      sts_prev_q <= sts_cur;
    end
  end

  assign sts_cur    = '{ovf: ovf_q, full: full};
  assign sts_de_o   = (sts_cur != sts_prev_q);
  assign sts_d_o    = sts_de_o ? sts_cur : 2'b00;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_prim_subreg_cmdq.sv
// tb/tb_prim_subreg_cmdq.sv - directed scoreboard bench for prim_subreg_cmdq
module tb_prim_subreg_cmdq;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          qe_i;
  logic [DW-1:0] q_i;
  logic          cmd_valid_o;
  logic [DW-1:0] cmd_data_o;
  logic          cmd_ready_i;
  logic [2:0]    lvl_o;
  logic          ovf_clr_i;
  logic          sts_de_o;
  logic [1:0]    sts_d_o;
  logic [7:0]    drop_cnt_o;

  int vecs = 0;
  int errs = 0;
  int mlvl = 0;
  logic [DW-1:0] sb[$];

  prim_subreg_cmdq #(.DW(DW), .Depth(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .qe_i        (qe_i),
    .q_i         (q_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_ready_i (cmd_ready_i),
    .lvl_o       (lvl_o),
    .ovf_clr_i   (ovf_clr_i),
    .sts_de_o    (sts_de_o),
    .sts_d_o     (sts_d_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of stimulus from the negedge; pops are scored before the edge.
  task automatic step(input logic qe, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic pop_m, push_m;
    logic [DW-1:0] exp_d;
    qe_i = qe; q_i = d; cmd_ready_i = rdy; ovf_clr_i = clr;
    #1;
    check("valid", 32'(cmd_valid_o), 32'(mlvl != 0));
    pop_m = (mlvl != 0) && rdy && !rst_i;
    if (pop_m) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_d = sb.pop_front();
        check("head_data", cmd_data_o, exp_d);
      end
    end
    push_m = qe && ((mlvl < DEPTH) || pop_m) && !rst_i;
    if (push_m) sb.push_back(d);
    if (rst_i) begin
      sb.delete();
      mlvl = 0;
    end else begin
      mlvl = mlvl + int'(push_m) - int'(pop_m);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    qe_i = 1'b0; ovf_clr_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; qe_i = 1'b0; q_i = '0; cmd_ready_i = 1'b0; ovf_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_lvl", 32'(lvl_o), 32'd0);
    check("rst_drop", 32'(drop_cnt_o), 32'd0);
    check("rst_de", 32'(sts_de_o), 32'd0);
    check("rst_d", 32'(sts_d_o), 32'd0);

    // Single write, popped as soon as it appears
    step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    check("single_lvl", 32'(lvl_o), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("single_lvl0", 32'(lvl_o), 32'd0);
    check("single_de", 32'(sts_de_o), 32'd0);

    // Burst to full, then drain in order
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h10 + i, 1'b0, 1'b0);
      if (i == 2) check("burst_de_early", 32'(sts_de_o), 32'd0);
    end
    check("burst_lvl", 32'(lvl_o), 32'd4);
    check("burst_de", 32'(sts_de_o), 32'd1);
    check("burst_d", 32'(sts_d_o), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("burst_de_once", 32'(sts_de_o), 32'd0);
    check("burst_d_idle", 32'(sts_d_o), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("drain_de", 32'(sts_de_o), 32'd1);
    check("drain_d", 32'(sts_d_o), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("drain_lvl", 32'(lvl_o), 32'd0);

    // Overflow: fill, three drops, then clear
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + i, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hD0 + i, 1'b0, 1'b0);
      if (i == 0) begin
        check("ovf_de", 32'(sts_de_o), 32'd1);
        check("ovf_d", 32'(sts_d_o), 32'd3);
        check("ovf_cnt1", 32'(drop_cnt_o), 32'd1);
      end
    end
    check("ovf_cnt3", 32'(drop_cnt_o), 32'd3);
    check("ovf_lvl", 32'(lvl_o), 32'd4);
    check("ovf_de_once", 32'(sts_de_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_cnt", 32'(drop_cnt_o), 32'd0);
    check("clr_de", 32'(sts_de_o), 32'd1);
    check("clr_d", 32'(sts_d_o), 32'd1);

    // Full queue: simultaneous push and pop is not a drop
    step(1'b1, 32'h99, 1'b1, 1'b0);
    check("pp_lvl", 32'(lvl_o), 32'd4);
    check("pp_cnt", 32'(drop_cnt_o), 32'd0);
    check("pp_de", 32'(sts_de_o), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("pp_lvl0", 32'(lvl_o), 32'd0);

    // Clear colliding with a drop
    for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + i, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hE0 + i, 1'b0, 1'b0);
    check("col_cnt5", 32'(drop_cnt_o), 32'd5);
    step(1'b1, 32'hEE, 1'b0, 1'b1);
    check("col_cnt", 32'(drop_cnt_o), 32'd1);
    check("col_de", 32'(sts_de_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("col_ovf_was_set", 32'(sts_de_o), 32'd1);
    check("col_clr_d", 32'(sts_d_o), 32'd1);

    // Reset with three entries queued
    step(1'b0, '0, 1'b1, 1'b0);
    check("prerst_lvl", 32'(lvl_o), 32'd3);
    rst_i = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    rst_i = 1'b0;
    check("mrst_valid", 32'(cmd_valid_o), 32'd0);
    check("mrst_lvl", 32'(lvl_o), 32'd0);
    check("mrst_cnt", 32'(drop_cnt_o), 32'd0);
    check("mrst_de", 32'(sts_de_o), 32'd0);
    step(1'b1, 32'h55, 1'b1, 1'b0);
    check("post_lvl", 32'(lvl_o), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_lvl0", 32'(lvl_o), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 4; i++) step(1'b1, 32'h30 + i, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) step(1'b1, 32'hF00 + i, 1'b0, 1'b0);
    check("sat_cnt", 32'(drop_cnt_o), 32'd255);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("sat_lvl0", 32'(lvl_o), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/prim_subreg_cmdq.md
Name: prim_subreg_cmdq

Overview:
- HW-side consumer of a software-written register field.
- Captures every software write strobe (qe) and its value (q) from a register slice into a small in-order queue.
- Presents the queued values to hardware over a valid/ready handshake, so back-to-back software writes are never lost while the consumer is busy.
- Reports queue status back into a status register through a hardware-write pair (de/d): overflow is sticky and software clears it.

Parameters:
- DW, 32, data width of the captured register field.
- Depth, 4, queue entries; legal values 1..16.
- CntW, $clog2(Depth+1), width of the occupancy count; derived, not overridden.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- qe_i  in  1  write strobe from register slice; q_i carries the new value in the same cycle.
- q_i  in  DW  register field value.
- cmd_valid_o  out  1  queue head valid.
- cmd_data_o  out  DW  queue head data.
- cmd_ready_i  in  1  consumer accepts the head.
- lvl_o  out  CntW  current occupancy.
- ovf_clr_i  in  1  software clear of overflow status (W1C strobe).
- sts_de_o  out  1  status write-enable to status register.
- sts_d_o  out  2  status value, {ovf, full}.
- drop_cnt_o  out  8  saturating count of dropped writes.

Behaviour:
- Reset: synchronous, takes effect on the clk_i edge with rst_i=1. All outputs are 0 after reset; pointers, occupancy and drop count are 0; queue contents are don't-care.
- Reset mid-operation flushes all entries. No partial pop occurs and no sts_de_o pulse is issued.
- push = qe_i & (!full | pop); pop = cmd_valid_o & cmd_ready_i.
  - A write that arrives in the same cycle as a pop on a full queue is accepted.
- Latency: an accepted push becomes visible on cmd_valid_o/cmd_data_o on the next cycle. There is no combinational fall-through.
- cmd_data_o stays stable while cmd_valid_o=1 and cmd_ready_i=0. cmd_valid_o never drops without a pop.
- Order: strict FIFO. Pointers wrap modulo Depth, so non-power-of-2 Depth must wrap explicitly.
- lvl_o: +1 on push only, -1 on pop only, unchanged on push+pop or on neither. Range is 0..Depth.
- full = (lvl == Depth); empty = (lvl == 0).
- Drop: qe_i=1 while full and no pop in that cycle.
  - The value is discarded.
  - ovf sets on the next cycle.
  - drop_cnt_o increments and saturates at 255.
- Overflow clear: ovf_clr_i=1 clears ovf and drop_cnt_o next cycle.
  - If a drop occurs in the same cycle, set wins: ovf=1 and drop_cnt_o=1.
- Status feedback: sts_de_o=1 for exactly one cycle, in the cycle after {ovf,full} changes. sts_d_o carries the new value in that cycle and is 0 otherwise.
- qe_i and ovf_clr_i are single-cycle strobes. Consecutive-cycle strobes are legal and each is handled independently.
- Depth=1: push is allowed only when empty or popping; full is then equivalent to cmd_valid_o.

Decomposition:
- prim_subreg_pkg gains typedef cmdq_sts_t (packed struct: logic ovf, logic full) and constant CmdqDropCntW=8.
- One sub-module: prim_subreg_cmdq_fifo, holding storage array, rd/wr pointers, occupancy and push/pop qualification.
- The top level holds overflow, drop count and status-change pulse logic.

Test Plan (DW=32, Depth=4):
- Single write: qe_i with q_i=0xA5A5_0001, ready=1 -> cmd_valid_o=1 next cycle with data 0xA5A5_0001; popped same cycle; lvl_o returns to 0.
- Burst of 4 writes (0x10..0x13), ready=0 -> lvl_o=4; sts_de_o pulses once with sts_d_o=2'b01; raise ready -> data 0x10,0x11,0x12,0x13 in order; final sts_de_o pulse with sts_d_o=2'b00.
- Overflow:
  - Fill 4 entries, then 3 more writes with ready=0 -> drop_cnt_o=3, ovf=1, sts_d_o=2'b11 pulse; queued data still 0x10..0x13.
  - ovf_clr_i -> drop_cnt_o=0, ovf=0.
- Full push+pop: queue full, qe_i=1 with q_i=0x99 and ready=1 in the same cycle -> no drop; lvl_o stays 4; 0x99 emerges last.
- Clear vs drop collision: full queue, ovf already set, drop_cnt_o=5; ovf_clr_i and a dropped qe_i in the same cycle -> next cycle ovf=1, drop_cnt_o=1.
- Reset mid-operation: lvl_o=3, assert rst_i one cycle -> cmd_valid_o=0, lvl_o=0, drop_cnt_o=0, sts_de_o=0; next write is accepted normally.
